// File: rtl/oled_arb_pkg.sv
// Shared constants, FSM state type and request priority helper for the OLED
// source arbiter.
package oled_arb_pkg;

  localparam int unsigned PIXEL_W = 16;
  localparam int unsigned NUM_SRC = 4;

  localparam logic [1:0] SRC_NUMBER     = 2'd0;
  localparam logic [1:0] SRC_WAM        = 2'd1;
  localparam logic [1:0] SRC_MOUSE      = 2'd2;
  localparam logic [1:0] SRC_REGRESSION = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } arb_state_e;

  // Lowest set request bit wins; an empty request falls back to regression.
  function automatic logic [1:0] resolve_target(input logic [NUM_SRC-1:0] r);
    logic [1:0] t;
    casez (r)
      4'b???1: t = SRC_NUMBER;
      4'b??10: t = SRC_WAM;
      4'b?100: t = SRC_MOUSE;
      default: t = SRC_REGRESSION;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/req_debouncer.sv
// Synchronises the raw switch requests, resolves priority and reports when the
// resolved target has held steady for DEBOUNCE_CYCLES cycles.
module req_debouncer
  import oled_arb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               CLOCK,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [1:0]         candidate,
  output logic               stable
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  STAB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;
  logic [1:0]         target;
  logic [CW-1:0]      stab_cnt;

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= req;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    target = resolve_target(sync_q2);
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= SRC_REGRESSION;
      stab_cnt  <= '0;
    end else if (target != candidate) begin
      candidate <= target;
      stab_cnt  <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign stable = (stab_cnt == STAB_MAX);

endmodule

// File: rtl/oled_source_arbiter.sv
// Chooses the pixel source feeding Oled_Display and the 7-segment owner,
// switching only on a frame boundary (or after a bounded wait for one).
module oled_source_arbiter
  import oled_arb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 4_000_000
) (
  input  logic                       CLOCK,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         req,
  input  logic                       frame_begin,
  input  logic [NUM_SRC*PIXEL_W-1:0] src_data,
  output logic [PIXEL_W-1:0]         oled_data,
  output logic [1:0]                 grant,
  output logic [NUM_SRC-1:0]         grant_onehot,
  output logic                       pending,
  output logic                       switch_pulse
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e         state;
  logic [TW-1:0]      to_cnt;
  logic [1:0]         candidate;
  logic               stable;
  logic [PIXEL_W-1:0] src_pix [NUM_SRC];

  req_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_req_debouncer (
    .CLOCK     (CLOCK),
    .reset_n   (reset_n),
    .req       (req),
    .candidate (candidate),
    .stable    (stable)
  );

  // A switch needs a stable candidate on the same cycle as the frame/timeout
  // event; otherwise the counter parks at TO_MAX and the switch fires as soon
  // as the candidate settles.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= SRC_REGRESSION;
      to_cnt       <= '0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (stable && (candidate != grant)) begin
            state  <= PENDING;
            to_cnt <= '0;
          end
        end
        PENDING: begin
          if (stable && (candidate == grant)) begin
            state <= IDLE;
          end else if (stable && (frame_begin || (to_cnt == TO_MAX))) begin
            grant        <= candidate;
            switch_pulse <= 1'b1;
            state        <= IDLE;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pending      = (state == PENDING);
  assign grant_onehot = 4'b0001 << grant;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_pix[i] = src_data[i*PIXEL_W +: PIXEL_W];
    end
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      oled_data <= '0;
    end else begin
      oled_data <= src_pix[grant];
    end
  end

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Directed bench for oled_source_arbiter with short debounce/timeout settings.
module tb_oled_source_arbiter;

  logic        CLOCK = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic        frame_begin = 1'b0;
  logic [63:0] src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
  logic [15:0] oled_data;
  logic [1:0]  grant;
  logic [3:0]  grant_onehot;
  logic        pending;
  logic        switch_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  oled_source_arbiter #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .CLOCK        (CLOCK),
    .reset_n      (reset_n),
    .req          (req),
    .frame_begin  (frame_begin),
    .src_data     (src_data),
    .oled_data    (oled_data),
    .grant        (grant),
    .grant_onehot (grant_onehot),
    .pending      (pending),
    .switch_pulse (switch_pulse)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK);
      if (switch_pulse === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held
    tick(2);
    check("rst_grant", 32'(grant), 32'd3);
    check("rst_oled", 32'(oled_data), 32'h0000);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_pulse", 32'(switch_pulse), 32'd0);

    // Release: regression pixel one cycle later
    reset_n = 1'b1;
    tick(1);
    check("rel_oled", 32'(oled_data), 32'hDDDD);
    check("rel_grant", 32'(grant), 32'd3);
    check("rel_onehot", 32'(grant_onehot), 32'h8);
    check("rel_pending", 32'(pending), 32'd0);

    // Normal switch to mouse: PENDING on the 7th edge after the req change
    req = 4'b0100;
    tick(6);
    check("norm_pend_early", 32'(pending), 32'd0);
    tick(1);
    check("norm_pend_rise", 32'(pending), 32'd1);
    tick(9);
    check("norm_pend_hold", 32'(pending), 32'd1);
    check("norm_grant_old", 32'(grant), 32'd3);
    frame_begin = 1'b1;
    tick(1);
    frame_begin = 1'b0;
    check("norm_grant", 32'(grant), 32'd2);
    check("norm_pulse", 32'(switch_pulse), 32'd1);
    check("norm_pend_fall", 32'(pending), 32'd0);
    check("norm_oled_lag", 32'(oled_data), 32'hDDDD);
    tick(1);
    check("norm_oled", 32'(oled_data), 32'hCCCC);
    check("norm_onehot", 32'(grant_onehot), 32'h4);
    check("norm_pulse_off", 32'(switch_pulse), 32'd0);
    check("norm_pulse_cnt", 32'(pulse_cnt), 32'd1);

    // Priority: number beats wam and mouse
    req = 4'b0111;
    tick(7);
    check("prio0_pend", 32'(pending), 32'd1);
    frame_begin = 1'b1;
    tick(1);
    frame_begin = 1'b0;
    check("prio0_grant", 32'(grant), 32'd0);
    check("prio0_onehot", 32'(grant_onehot), 32'h1);
    tick(1);
    check("prio0_oled", 32'(oled_data), 32'hAAAA);

    req = 4'b0110;
    tick(7);
    check("prio1_pend", 32'(pending), 32'd1);
    frame_begin = 1'b1;
    tick(1);
    frame_begin = 1'b0;
    check("prio1_grant", 32'(grant), 32'd1);
    tick(1);
    check("prio1_oled", 32'(oled_data), 32'hBBBB);
    check("prio_pulse_cnt", 32'(pulse_cnt), 32'd3);

    // Back to regression (empty request)
    req = 4'b0000;
    tick(7);
    frame_begin = 1'b1;
    tick(1);
    frame_begin = 1'b0;
    check("back_grant", 32'(grant), 32'd3);
    tick(8);

    // Glitch rejection: 2-cycle number request
    req = 4'b0001;
    tick(2);
    req = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_pend", 32'(pending), 32'd0);
    end
    check("glitch_grant", 32'(grant), 32'd3);
    check("glitch_pulse_cnt", 32'(pulse_cnt), 32'd4);

    // Timeout: pending for exactly 16 cycles
    req = 4'b0100;
    tick(7);
    check("to_pend_rise", 32'(pending), 32'd1);
    tick(15);
    check("to_pend_last", 32'(pending), 32'd1);
    check("to_grant_old", 32'(grant), 32'd3);
    tick(1);
    check("to_pend_fall", 32'(pending), 32'd0);
    check("to_grant", 32'(grant), 32'd2);
    check("to_pulse", 32'(switch_pulse), 32'd1);
    check("to_pulse_cnt", 32'(pulse_cnt), 32'd5);

    // Collision: frame_begin on the timeout cycle
    req = 4'b0000;
    tick(7);
    check("col_pend", 32'(pending), 32'd1);
    tick(15);
    frame_begin = 1'b1;
    tick(1);
    frame_begin = 1'b0;
    check("col_grant", 32'(grant), 32'd3);
    check("col_pulse", 32'(switch_pulse), 32'd1);
    tick(3);
    check("col_pulse_cnt", 32'(pulse_cnt), 32'd6);
    check("col_pulse_off", 32'(switch_pulse), 32'd0);

    // Cancel: request withdrawn before any frame
    req = 4'b0100;
    tick(7);
    check("can_pend", 32'(pending), 32'd1);
    req = 4'b0000;
    tick(6);
    check("can_pend_hold", 32'(pending), 32'd1);
    tick(1);
    check("can_pend_fall", 32'(pending), 32'd0);
    check("can_grant", 32'(grant), 32'd3);
    tick(3);
    check("can_pulse_cnt", 32'(pulse_cnt), 32'd6);

    // Asynchronous reset in the middle of PENDING
    req = 4'b0100;
    tick(7);
    check("ar_pend", 32'(pending), 32'd1);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    check("ar_pending", 32'(pending), 32'd0);
    check("ar_grant", 32'(grant), 32'd3);
    check("ar_onehot", 32'(grant_onehot), 32'h8);
    check("ar_oled", 32'(oled_data), 32'h0000);
    check("ar_pulse", 32'(switch_pulse), 32'd0);
    req = 4'b0000;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("ar_post_grant", 32'(grant), 32'd3);
    check("ar_post_oled", 32'(oled_data), 32'hDDDD);
    check("ar_pulse_cnt", 32'(pulse_cnt), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
